// File: rtl/cycle_sequencer_if.sv
// Bus between the instruction controller and the cycle sequencer.
// The master drives the controller-side inputs; the slave is the sequencer.
interface cycle_sequencer_if;
    logic       rdy;
    logic [7:0] db_in;
    logic [7:0] IR;
    logic [2:0] cycle;
    logic       page_cross;
    logic       branch_taken;
    logic       irq_n;
    logic       nmi_n;
    logic       i_flag;
    logic [7:0] PD;
    logic       I_cycle;
    logic       R_cycle;
    logic       sync;
    logic [1:0] int_type;

    modport master (
        output rdy, db_in, IR, cycle, page_cross, branch_taken, irq_n, nmi_n, i_flag,
        input  PD, I_cycle, R_cycle, sync, int_type
    );

    modport slave (
        input  rdy, db_in, IR, cycle, page_cross, branch_taken, irq_n, nmi_n, i_flag,
        output PD, I_cycle, R_cycle, sync, int_type
    );
endinterface

// File: rtl/cycle_sequencer.sv
// 6502-style cycle sequencer: decodes the final cycle of each instruction,
// stretches it for page crossings / taken branches, and forces BRK on interrupts.
module cycle_sequencer (
    input  logic              clk_ph1,
    input  logic              rst,
    cycle_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        INT_NONE  = 2'b00,
        INT_IRQ   = 2'b01,
        INT_NMI   = 2'b10,
        INT_RESET = 2'b11
    } int_t;

    typedef struct packed {
        logic [2:0] base;
        logic       idx_rd;
        logic       branch;
    } dec_t;

    function automatic dec_t decode(input logic [7:0] ir);
        logic [1:0] cc;
        logic [2:0] bbb;
        logic [2:0] aaa;
        dec_t       d;
        cc  = ir[1:0];
        bbb = ir[4:2];
        aaa = ir[7:5];
        d   = '{base: 3'd1, idx_rd: 1'b0, branch: 1'b0};
        if (ir == 8'h00)
            d.base = 3'd6;
        else if (ir == 8'h20 || ir == 8'h40 || ir == 8'h60)
            d.base = 3'd5;
        else if (ir == 8'h4C)
            d.base = 3'd2;
        else if (ir == 8'h6C)
            d.base = 3'd4;
        else if (ir == 8'h08 || ir == 8'h48)
            d.base = 3'd2;
        else if (ir == 8'h28 || ir == 8'h68)
            d.base = 3'd3;
        else if (ir[4:0] == 5'b10000)
            d.branch = 1'b1;
        else if (ir[3:0] == 4'h8 || ir[3:0] == 4'hA)
            d.base = 3'd1;
        else begin
            case (cc)
                2'b01: begin
                    case (bbb)
                        3'b000: d.base = 3'd5;
                        3'b001: d.base = 3'd2;
                        3'b010: d.base = 3'd1;
                        3'b011: d.base = 3'd3;
                        3'b100: begin
                            d.base   = (aaa == 3'b100) ? 3'd5 : 3'd4;
                            d.idx_rd = (aaa != 3'b100);
                        end
                        3'b101: d.base = 3'd3;
                        default: begin
                            d.base   = (aaa == 3'b100) ? 3'd4 : 3'd3;
                            d.idx_rd = (aaa != 3'b100);
                        end
                    endcase
                end
                2'b10: begin
                    if (aaa == 3'b100) begin
                        case (bbb)
                            3'b001:  d.base = 3'd2;
                            3'b101:  d.base = 3'd3;
                            3'b011:  d.base = 3'd3;
                            3'b111:  d.base = 3'd4;
                            default: d.base = 3'd1;
                        endcase
                    end else if (aaa == 3'b101) begin
                        case (bbb)
                            3'b001:  d.base = 3'd2;
                            3'b101:  d.base = 3'd3;
                            3'b011:  d.base = 3'd3;
                            3'b111: begin
                                d.base   = 3'd3;
                                d.idx_rd = 1'b1;
                            end
                            default: d.base = 3'd1;
                        endcase
                    end else begin
                        // read-modify-write group
                        case (bbb)
                            3'b001:  d.base = 3'd4;
                            3'b101:  d.base = 3'd5;
                            3'b011:  d.base = 3'd5;
                            3'b111:  d.base = 3'd6;
                            default: d.base = 3'd1;
                        endcase
                    end
                end
                2'b00: begin
                    case (bbb)
                        3'b001: if (aaa == 3'b001 || aaa[2]) d.base = 3'd2;
                        3'b011: if (aaa == 3'b001 || aaa[2]) d.base = 3'd3;
                        3'b101: if (aaa == 3'b100 || aaa == 3'b101) d.base = 3'd3;
                        3'b111: begin
                            if (aaa == 3'b101) begin
                                d.base   = 3'd3;
                                d.idx_rd = 1'b1;
                            end
                        end
                        default: d.base = 3'd1;
                    endcase
                end
                default: d.base = 3'd1;
            endcase
        end
        return d;
    endfunction

    logic [7:0] r_pd_hold;
    logic [1:0] r_ext;
    logic       r_nmi_pend;
    logic       r_nmi_prev;
    logic       r_reset_pend;
    int_t       r_int_type;

    dec_t       w_dec;
    logic       w_sync;
    logic       w_ext_now;
    logic [2:0] w_last;
    logic       w_r_cycle;
    logic       w_irq_act;
    logic       w_nmi_fall;
    int_t       w_sel;
    logic       w_take_int;
    logic       w_t0_go;
    logic       w_force_next;
    logic [7:0] w_pd;

    assign w_dec  = decode(bus.IR);
    assign w_sync = (bus.cycle == 3'd0);

    // Extension must already count in the cycle that discovers it, so R_cycle is held off now.
    assign w_ext_now = (w_dec.idx_rd && r_ext == 2'd0 && bus.cycle == w_dec.base && bus.page_cross)
                     || (w_dec.branch && bus.cycle == 3'd1 && bus.branch_taken)
                     || (w_dec.branch && bus.cycle == 3'd2 && r_ext == 2'd1 && bus.page_cross);
    assign w_last    = w_dec.base + {1'b0, r_ext} + {2'b00, w_ext_now};
    assign w_r_cycle = bus.rdy && (bus.cycle == w_last);

    assign w_irq_act  = !bus.irq_n && !bus.i_flag;
    assign w_nmi_fall = r_nmi_prev && !bus.nmi_n;
    assign w_sel      = r_reset_pend ? INT_RESET :
                        r_nmi_pend   ? INT_NMI   :
                        w_irq_act    ? INT_IRQ   : INT_NONE;
    assign w_take_int = (w_sel != INT_NONE);
    assign w_t0_go    = w_sync && bus.rdy;
    assign w_force_next = r_reset_pend || r_nmi_pend || w_nmi_fall || w_irq_act;

    assign w_pd = w_sync ? (w_take_int ? 8'h00 : bus.db_in) : r_pd_hold;

    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            r_pd_hold    <= 8'h00;
            r_ext        <= 2'd0;
            r_nmi_pend   <= 1'b0;
            r_nmi_prev   <= 1'b1;
            r_reset_pend <= 1'b1;
            r_int_type   <= INT_NONE;
        end else begin
            r_pd_hold  <= w_pd;
            r_nmi_prev <= bus.nmi_n;

            if (w_nmi_fall)
                r_nmi_pend <= 1'b1;
            else if (w_t0_go && w_sel == INT_NMI)
                r_nmi_pend <= 1'b0;

            if (w_t0_go)
                r_reset_pend <= 1'b0;

            if (w_r_cycle)
                r_ext <= 2'd0;
            else if (bus.rdy && w_ext_now)
                r_ext <= r_ext + 2'd1;

            // Source stays latched across back-to-back forced fetches.
            if (w_t0_go)
                r_int_type <= w_sel;
            else if (w_r_cycle && !w_force_next)
                r_int_type <= INT_NONE;
        end
    end

    assign bus.PD       = w_pd;
    assign bus.I_cycle  = bus.rdy;
    assign bus.R_cycle  = w_r_cycle;
    assign bus.sync     = w_sync;
    assign bus.int_type = r_int_type;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: the bench plays the instruction controller
// and checks every cycle against hand-computed expectations.
module tb_cycle_sequencer;
    logic clk_ph1 = 1'b0;
    logic rst     = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    cycle_sequencer_if bus();
    cycle_sequencer dut (.clk_ph1(clk_ph1), .rst(rst), .bus(bus));

    always #5 clk_ph1 = ~clk_ph1;

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic set(input logic [2:0] c, input logic [7:0] ir, input logic [7:0] db);
        bus.cycle = c;
        bus.IR    = ir;
        bus.db_in = db;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_ph1);
        #1;
    endtask

    initial begin
        bus.rdy = 1'b1; bus.db_in = 8'hA9; bus.IR = 8'hEA; bus.cycle = 3'd7;
        bus.page_cross = 1'b0; bus.branch_taken = 1'b0;
        bus.irq_n = 1'b1; bus.nmi_n = 1'b1; bus.i_flag = 1'b0;
        tick(); tick();

        // reset state
        chk8("rst_pd", bus.PD, 8'h00);
        chk8("rst_int_type", {6'd0, bus.int_type}, 8'h00);
        chk1("rst_sync", bus.sync, 1'b0);
        chk1("rst_icycle", bus.I_cycle, 1'b1);
        chk1("rst_rcycle", bus.R_cycle, 1'b0);

        // release: forced RESET BRK
        rst = 1'b0;
        set(3'd7, 8'hEA, 8'hA9); tick();
        set(3'd0, 8'hEA, 8'hA9);
        chk1("reset_t0_sync", bus.sync, 1'b1);
        chk8("reset_t0_pd", bus.PD, 8'h00);
        tick();
        for (int c = 1; c <= 6; c++) begin
            set(3'(c), 8'h00, 8'h55);
            if (c == 1) begin
                chk8("reset_t1_pd", bus.PD, 8'h00);
                chk8("reset_t1_int", {6'd0, bus.int_type}, 8'h03);
            end
            chk1("reset_brk_rcycle", bus.R_cycle, c == 6);
            tick();
        end

        // LDA abs,X with page cross at T3
        set(3'd0, 8'h00, 8'hBD);
        chk8("lda_t0_pd", bus.PD, 8'hBD);
        chk8("lda_t0_int", {6'd0, bus.int_type}, 8'h00);
        tick();
        for (int c = 1; c <= 4; c++) begin
            bus.page_cross = (c == 3);
            set(3'(c), 8'hBD, 8'h33);
            if (c == 2) chk8("lda_pd_hold", bus.PD, 8'hBD);
            chk1("lda_px_rcycle", bus.R_cycle, c == 4);
            tick();
        end
        bus.page_cross = 1'b0;
        // same opcode without cross: ext must have cleared
        set(3'd0, 8'hBD, 8'hBD); tick();
        for (int c = 1; c <= 3; c++) begin
            set(3'(c), 8'hBD, 8'h33);
            chk1("lda_nopx_rcycle", bus.R_cycle, c == 3);
            tick();
        end

        // BNE taken with page cross
        set(3'd0, 8'hBD, 8'hD0); tick();
        bus.branch_taken = 1'b1;
        set(3'd1, 8'hD0, 8'h10);
        chk1("bne_t1_rcycle", bus.R_cycle, 1'b0);
        tick();
        bus.branch_taken = 1'b0; bus.page_cross = 1'b1;
        set(3'd2, 8'hD0, 8'h10);
        chk1("bne_t2_rcycle", bus.R_cycle, 1'b0);
        tick();
        bus.page_cross = 1'b0;
        set(3'd3, 8'hD0, 8'h10);
        chk1("bne_t3_rcycle", bus.R_cycle, 1'b1);
        tick();
        // BNE not taken ends at T1
        set(3'd0, 8'hD0, 8'hD0); tick();
        set(3'd1, 8'hD0, 8'h10);
        chk1("bne_nt_rcycle", bus.R_cycle, 1'b1);
        tick();

        // STA abs with rdy low in T2
        set(3'd0, 8'hD0, 8'h8D); tick();
        set(3'd1, 8'h8D, 8'h11);
        chk1("sta_t1_rcycle", bus.R_cycle, 1'b0);
        tick();
        bus.rdy = 1'b0; bus.page_cross = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set(3'd2, 8'h8D, 8'(8'h20 + k));
            chk1("sta_frz_icycle", bus.I_cycle, 1'b0);
            chk1("sta_frz_rcycle", bus.R_cycle, 1'b0);
            chk8("sta_frz_pd", bus.PD, 8'h8D);
            tick();
        end
        bus.rdy = 1'b1; bus.page_cross = 1'b0;
        set(3'd2, 8'h8D, 8'h22);
        chk1("sta_t2_icycle", bus.I_cycle, 1'b1);
        chk1("sta_t2_rcycle", bus.R_cycle, 1'b0);
        tick();
        set(3'd3, 8'h8D, 8'h33);
        chk1("sta_t3_rcycle", bus.R_cycle, 1'b1);
        chk8("sta_t3_pd", bus.PD, 8'h8D);
        tick();

        // NMI falls mid LDA zp while IRQ is also active
        set(3'd0, 8'h8D, 8'hA5); tick();
        bus.nmi_n = 1'b0; bus.irq_n = 1'b0;
        set(3'd1, 8'hA5, 8'h40);
        chk1("ldazp_t1_rcycle", bus.R_cycle, 1'b0);
        tick();
        set(3'd2, 8'hA5, 8'h40);
        chk1("ldazp_t2_rcycle", bus.R_cycle, 1'b1);
        tick();
        set(3'd0, 8'hA5, 8'hA9);
        chk8("nmi_t0_pd", bus.PD, 8'h00);
        tick();
        for (int c = 1; c <= 6; c++) begin
            set(3'(c), 8'h00, 8'h66);
            if (c == 1) chk8("nmi_t1_int", {6'd0, bus.int_type}, 8'h02);
            chk1("nmi_brk_rcycle", bus.R_cycle, c == 6);
            tick();
        end
        set(3'd0, 8'h00, 8'hA9);
        chk8("irq_t0_pd", bus.PD, 8'h00);
        chk8("irq_t0_int_held", {6'd0, bus.int_type}, 8'h02);
        tick();
        bus.irq_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            set(3'(c), 8'h00, 8'h66);
            if (c == 1) chk8("irq_t1_int", {6'd0, bus.int_type}, 8'h01);
            chk1("irq_brk_rcycle", bus.R_cycle, c == 6);
            tick();
        end
        set(3'd0, 8'h00, 8'hEA);
        chk8("post_irq_int", {6'd0, bus.int_type}, 8'h00);
        chk8("post_irq_pd", bus.PD, 8'hEA);
        tick();
        set(3'd1, 8'hEA, 8'h00);
        chk1("nop_rcycle", bus.R_cycle, 1'b1);
        tick();

        // INC abs,X: no extension for RMW
        set(3'd0, 8'hEA, 8'hFE);
        chk1("inc_t0_sync", bus.sync, 1'b1);
        tick();
        for (int c = 1; c <= 6; c++) begin
            bus.page_cross = (c >= 3);
            set(3'(c), 8'hFE, 8'h77);
            chk1("inc_rcycle", bus.R_cycle, c == 6);
            chk1("inc_sync", bus.sync, 1'b0);
            tick();
        end
        bus.page_cross = 1'b0;

        // reset mid LDA abs,X after ext was set; nmi_n still low at release
        set(3'd0, 8'hFE, 8'hBD); tick();
        for (int c = 1; c <= 3; c++) begin
            bus.page_cross = (c == 3);
            set(3'(c), 8'hBD, 8'h33);
            if (c == 3) chk1("rst2_t3_rcycle", bus.R_cycle, 1'b0);
            tick();
        end
        bus.page_cross = 1'b0;
        set(3'd4, 8'hBD, 8'h33);
        rst = 1'b1;
        #1;
        chk8("rst2_pd", bus.PD, 8'h00);
        chk8("rst2_int", {6'd0, bus.int_type}, 8'h00);
        tick();
        rst = 1'b0;
        set(3'd3, 8'hBD, 8'h33);
        chk1("rst2_ext_discard", bus.R_cycle, 1'b1);
        tick();
        set(3'd0, 8'hBD, 8'hA9);
        chk8("rst2_t0_pd", bus.PD, 8'h00);
        tick();
        for (int c = 1; c <= 6; c++) begin
            set(3'(c), 8'h00, 8'h55);
            if (c == 1) chk8("rst2_prio_int", {6'd0, bus.int_type}, 8'h03);
            chk1("rst2_brk_rcycle", bus.R_cycle, c == 6);
            tick();
        end
        set(3'd0, 8'h00, 8'hA9);
        chk8("rst2_nmi_t0_pd", bus.PD, 8'h00);
        tick();
        set(3'd1, 8'h00, 8'h55);
        chk8("rst2_nmi_int", {6'd0, bus.int_type}, 8'h02);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
